uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side buffer between the uart core and the data bus. Captures each
//   byte the core flags ready and acknowledges it by pulsing the core's clear
//   input. Holds up to DEPTH bytes in first-word-fall-through order so software
//   polling at 57600 baud does not lose characters.
//   Reports a sticky overflow flag when a byte arrives while the buffer is full.
// PARAMETERS
//   DEPTH  16  number of byte entries; must be a power of two, >= 2
//   AW     4   pointer width; must equal log2(DEPTH)
// PORTS
//   clk       in   1     system clock; all registers update on its falling edge
//   rst       in   1     asynchronous, active-high reset
//   rx_data   in   8     received byte from uart core (in_buffer)
//   rx_rdy    in   1     byte-ready flag from uart core (data_rdy)
//   rx_clear  out  1     one-cycle acknowledge to uart core (clear)
//   pop       in   1     remove head byte; sampled on the falling edge
//   dout      out  8     head byte; 8'h00 when empty
//   empty     out  1     1 when count == 0
//   full      out  1     1 when count == DEPTH
//   count     out  AW+1  number of stored bytes, 0..DEPTH
//   overflow  out  1     sticky: a byte was dropped because the FIFO was full
//   ovf_clr   in   1     clears overflow
// BEHAVIOUR
//   Reset (async, immediate):
//   - wptr = rptr = 0, count = 0, empty = 1, full = 0
//   - overflow = 0, rx_clear = 0, state = IDLE
//   - storage array is not reset
//   Capture FSM (Moore; rx_clear = 1 only in ACK):
//   - IDLE: rx_rdy = 1 -> push rx_data, go to ACK; else stay
//   - ACK: rx_clear = 1 for exactly one cycle; go to WAIT unconditionally
//   - WAIT: rx_rdy = 0 -> IDLE; else stay. The core drops rx_rdy on the edge
//     where it samples rx_clear, so each byte is captured exactly once.
//   - Latency: byte visible at dout / count one falling edge after rx_rdy is
//     first sampled high.
//   Push (IDLE with rx_rdy = 1):
//   - Accepted if !full, or if full and pop = 1 on the same edge.
//   - Accept writes mem[wptr] and increments wptr.
//   - Not accepted: byte dropped, overflow <= 1, pointers unchanged; ACK and
//     rx_clear still occur.
//   Pop:
//   - pop = 1 and !empty: rptr increments.
//   - pop = 1 and empty: ignored, no state change.
//   Pointers: AW bits, wrap DEPTH-1 -> 0 naturally.
//   Count update:
//   - push only: +1
//   - pop only: -1
//   - push and pop: unchanged
//   - push and pop while empty: pop ignored, count -> 1
//   - push and pop while full: both accepted, count stays DEPTH
//   Flags:
//   - empty and full are registered, derived from the next count
//   - full and empty are never both 1
//   - overflow: set has priority over ovf_clr on the same edge; otherwise
//     ovf_clr = 1 clears it
//   dout: combinational mem[rptr] gated to 8'h00 while empty; changes only
//     after the edge that updates rptr or count.
//   Reset mid-handshake: FSM returns to IDLE and rx_clear drops immediately.
//     If rx_rdy is still high after reset, the pending byte is captured again
//     (acceptable; the core is reset by the same rst).
// TESTING
//   1. Reset: assert rst mid-cycle -> empty = 1, full = 0, count = 0,
//      overflow = 0, rx_clear = 0, dout = 8'h00 with no clock edge.
//   2. Single byte: rx_data = 8'h41, rx_rdy pulse -> one edge later count = 1,
//      dout = 8'h41; rx_clear high one cycle; with rx_rdy held 5 cycles after
//      clear, count stays 1.
//   3. Fill and wrap: push 16 bytes 8'h00..8'h0F -> full = 1, count = 16;
//      pop 16 -> dout steps 00..0F, empty = 1; push 8'hAA -> stored at
//      index 0 after wrap.
//   4. Overflow: with full, push 8'h55 -> overflow = 1, count = 16, head
//      unchanged, rx_clear still pulses; ovf_clr -> overflow = 0.
//   5. Simultaneous ops: full + push 8'h77 + pop -> count 16, 8'h77 last out,
//      no overflow; empty + push 8'h33 + pop -> count 1, dout = 8'h33.
//   6. Pop while empty: 3 pops -> count 0, pointers unchanged; next push
//      8'h12 -> dout = 8'h12.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer between the uart core and the data bus.
// Captures each ready byte once, acks it with rx_clear, and serves it back first-word-fall-through.
//
//   state | meaning
//   IDLE  | waiting for rx_rdy; a byte is pushed when it is seen high
//   ACK   | rx_clear asserted for this single cycle
//   WAIT  | waiting for the core to drop rx_rdy
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rdy,
    output logic          rx_clear,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_CT = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];

    logic push_req, push_ok, pop_ok;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(negedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= rx_data;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rx_rdy) state_d = ACK;
            ACK:     state_d = WAIT;
            WAIT:    if (!rx_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A push into a full buffer is still accepted when a pop frees a slot on the same edge.
    always_comb begin
        push_req = (state_q == IDLE) && rx_rdy;
        pop_ok   = pop && !empty_q;
        push_ok  = push_req && (!full_q || pop);

        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;

        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - ONE;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CT);

        ovf_d = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    assign rx_clear = (state_q == ACK);
    assign dout     = empty_q ? 8'h00 : mem_q[rptr_q];
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rx_clear;
    logic       pop = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rx_clear(rx_clear), .pop(pop), .dout(dout), .empty(empty),
        .full(full), .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus a handshake phase (0 listen, 1 acking, 2 waiting for release).
    logic [7:0] mq[$];
    int         phase = 0;
    logic       movf  = 1'b0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            phase = 0;
            movf  = 1'b0;
        end else begin
            bit listen, accepted;
            listen   = (phase == 0) && rx_rdy;
            accepted = listen && (mq.size() < 16 || pop);
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (accepted) mq.push_back(rx_data);
            if (listen && !accepted) movf = 1'b1;
            else if (ovf_clr) movf = 1'b0;
            case (phase)
                0:       phase = rx_rdy ? 1 : 0;
                1:       phase = 2;
                default: phase = rx_rdy ? 2 : 0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_empty", 32'(empty), 32'(mq.size() == 0));
            chk("m_full", 32'(full), 32'(mq.size() == 16));
            chk("m_ovf", 32'(overflow), 32'(movf));
            chk("m_clear", 32'(rx_clear), 32'(phase == 1));
            chk("m_dout", 32'(dout), (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Core-like handshake: rx_rdy held through the ack cycle, dropped after.
    task automatic push_byte(input logic [7:0] b, input logic p);
        rx_data = b;
        rx_rdy  = 1'b1;
        pop     = p;
        cyc();
        pop = 1'b0;
        cyc();
        rx_rdy = 1'b0;
        cyc();
    endtask

    task automatic pop_one();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_clear", 32'(rx_clear), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        cyc();
        rst = 1'b0;
        cyc();

        // single byte, rx_rdy held long after the ack
        rx_data = 8'h41;
        rx_rdy  = 1'b1;
        cyc();
        chk("t2_count", 32'(count), 32'd1);
        chk("t2_dout", 32'(dout), 32'h41);
        chk("t2_clear_hi", 32'(rx_clear), 32'd1);
        cyc();
        chk("t2_clear_lo", 32'(rx_clear), 32'd0);
        repeat (5) cyc();
        chk("t2_hold_count", 32'(count), 32'd1);
        rx_rdy = 1'b0;
        cyc();
        cyc();
        pop_one();
        chk("t2_empty", 32'(empty), 32'd1);

        // reset asserted mid-cycle during a handshake
        rx_data = 8'h5A;
        rx_rdy  = 1'b1;
        cyc();
        chk("t1_pre_clear", 32'(rx_clear), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t1_clear", 32'(rx_clear), 32'd0);
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_full", 32'(full), 32'd0);
        chk("t1_ovf", 32'(overflow), 32'd0);
        chk("t1_dout", 32'(dout), 32'h00);
        rx_rdy = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // fill, drain in order, wrap
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", 32'(dout), 32'(i));
            pop_one();
        end
        chk("t3_empty", 32'(empty), 32'd1);
        push_byte(8'hAA, 1'b0);
        chk("t3_wrap_dout", 32'(dout), 32'hAA);
        chk("t3_wrap_idx0", 32'(dut.mem_q[0]), 32'hAA);
        pop_one();

        // overflow
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b0);
        rx_data = 8'h55;
        rx_rdy  = 1'b1;
        cyc();
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_count", 32'(count), 32'd16);
        chk("t4_head", 32'(dout), 32'h10);
        chk("t4_clear", 32'(rx_clear), 32'd1);
        cyc();
        rx_rdy = 1'b0;
        cyc();
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);

        // simultaneous push and pop while full
        push_byte(8'h77, 1'b1);
        chk("t5_full_count", 32'(count), 32'd16);
        chk("t5_full_ovf", 32'(overflow), 32'd0);
        chk("t5_new_head", 32'(dout), 32'h11);
        repeat (15) pop_one();
        chk("t5_last", 32'(dout), 32'h77);
        pop_one();
        chk("t5_drained", 32'(empty), 32'd1);

        // simultaneous push and pop while empty
        push_byte(8'h33, 1'b1);
        chk("t5_empty_count", 32'(count), 32'd1);
        chk("t5_empty_dout", 32'(dout), 32'h33);
        pop_one();

        // pops on an empty buffer are ignored
        repeat (3) pop_one();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_rptr", 32'(dut.rptr_q), 32'(dut.wptr_q));
        push_byte(8'h12, 1'b0);
        chk("t6_dout", 32'(dout), 32'h12);
        chk("t6_count1", 32'(count), 32'd1);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
